// File: rtl/signext_pipe.sv
// signext_pipe: LEGv8 immediate decode/extend with a DEPTH-entry result FIFO.
// Decodes the instruction format from opcode bits and extracts the immediate.
// The immediate is sign- or zero-extended to N bits. CB/B offsets are
// optionally pre-shifted by 2. Results are queued with valid/ready on both
// sides, and accepted unrecognised encodings are counted.
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/instr        : upstream handshake and instruction word
//   out_valid/out_ready            : downstream handshake
//   out_imm/out_fmt/out_bad        : head-of-queue result, zero when empty
//   bad_cnt                        : saturating count of accepted bad words
module signext_pipe #(
  parameter int unsigned N        = 64,
  parameter int unsigned DEPTH    = 2,
  parameter bit          SHIFT_BR = 1'b0,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_bad,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_D  = 3'd1;
  localparam logic [2:0] FMT_CB = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_I  = 3'd4;

  logic [N-1:0]  mem_imm [DEPTH];
  logic [2:0]    mem_fmt [DEPTH];
  logic          mem_bad [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] count, count_n;

  logic [N-1:0]  dec_imm;
  logic [2:0]    dec_fmt;
  logic          dec_bad;

  logic          push, pop;
  logic [N-1:0]  head_imm;
  logic [2:0]    head_fmt;
  logic          head_bad;

  // Format decode and immediate extension; first match wins.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_R;
    dec_bad = 1'b0;
    if (instr[31:21] == 11'b111_1100_0010 || instr[31:21] == 11'b111_1100_0000) begin
      dec_imm = {{(N-9){instr[20]}}, instr[20:12]};
      dec_fmt = FMT_D;
    end else if (instr[31:24] == 8'b1011_0100) begin
      dec_imm = {{(N-19){instr[23]}}, instr[23:5]};
      if (SHIFT_BR) dec_imm = dec_imm << 2;
      dec_fmt = FMT_CB;
    end else if (instr[31:26] == 6'b000101) begin
      dec_imm = {{(N-26){instr[25]}}, instr[25:0]};
      if (SHIFT_BR) dec_imm = dec_imm << 2;
      dec_fmt = FMT_B;
    end else if (instr[31:22] == 10'b10_0100_0100 || instr[31:22] == 10'b11_0100_0100) begin
      dec_imm = {{(N-12){1'b0}}, instr[21:10]};
      dec_fmt = FMT_I;
    end else if (instr[31:21] == 11'b100_0101_1000 || instr[31:21] == 11'b110_0101_1000 ||
                 instr[31:21] == 11'b100_0101_0000 || instr[31:21] == 11'b101_0101_0000) begin
      dec_fmt = FMT_R;
    end else begin
      dec_bad = 1'b1;
    end
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next pointer/occupancy state and the entry that will sit at the head.
  // The head bypasses the array when this cycle's push lands on it.
  always_comb begin
    wr_ptr_n = push ? PW'(wr_ptr + PW'(1)) : wr_ptr;
    rd_ptr_n = pop  ? PW'(rd_ptr + PW'(1)) : rd_ptr;
    count_n  = count;
    case ({push, pop})
      2'b10:   count_n = CW'(count + CW'(1));
      2'b01:   count_n = CW'(count - CW'(1));
      default: count_n = count;
    endcase
    if (push && (wr_ptr == rd_ptr_n)) begin
      head_imm = dec_imm;
      head_fmt = dec_fmt;
      head_bad = dec_bad;
    end else begin
      head_imm = mem_imm[rd_ptr_n];
      head_fmt = mem_fmt[rd_ptr_n];
      head_bad = mem_bad[rd_ptr_n];
    end
  end

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_ptr] <= dec_imm;
      mem_fmt[wr_ptr] <= dec_fmt;
      mem_bad[wr_ptr] <= dec_bad;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_fmt   <= '0;
      out_bad   <= 1'b0;
      bad_cnt   <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      in_ready  <= (count_n < CW'(DEPTH));
      out_valid <= (count_n != '0);
      out_imm   <= (count_n != '0) ? head_imm : '0;
      out_fmt   <= (count_n != '0) ? head_fmt : '0;
      out_bad   <= (count_n != '0) ? head_bad : 1'b0;
      if (push && dec_bad && (bad_cnt != '1)) bad_cnt <= CNT_W'(bad_cnt + CNT_W'(1));
    end
  end

endmodule

// File: tb/tb_signext_pipe.sv
// Directed bench for signext_pipe: decode/extension, FIFO backpressure,
// streaming, counter saturation and asynchronous reset.
module tb_signext_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;
  logic        in_ready, out_valid, out_bad;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic [7:0]  bad_cnt;

  logic        in_ready2, out_valid2, out_bad2;
  logic [63:0] out_imm2;
  logic [2:0]  out_fmt2;
  logic [7:0]  bad_cnt2;
  logic        out_ready2 = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  signext_pipe #(.N(64), .DEPTH(2), .SHIFT_BR(1'b0), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_bad(out_bad), .bad_cnt(bad_cnt)
  );

  signext_pipe #(.N(64), .DEPTH(2), .SHIFT_BR(1'b1), .CNT_W(8)) dut_sh (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .instr(instr), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_imm(out_imm2), .out_fmt(out_fmt2), .out_bad(out_bad2), .bad_cnt(bad_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one cycle, then sample.
  task automatic push_one(input logic [31:0] w);
    instr    = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] ldur(input logic [8:0] imm9);
    return {11'b111_1100_0010, imm9, 12'h000};
  endfunction

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_bad_cnt",   64'(bad_cnt),   64'd0);
    chk("rst_out_imm",   out_imm,        64'd0);
    tick();
    reset = 1'b1;
    #2;
    chk("rst_held_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // LDUR positive and negative offsets
    push_one(ldur(9'b0_1110_0011));
    chk("ldur_pos_valid", 64'(out_valid), 64'd1);
    chk("ldur_pos_imm",   out_imm,        64'h0000_0000_0000_00E3);
    chk("ldur_pos_fmt",   64'(out_fmt),   64'd1);
    chk("ldur_pos_bad",   64'(out_bad),   64'd0);
    push_one(ldur(9'b1_1110_0011));
    chk("ldur_neg_imm",   out_imm,        64'hFFFF_FFFF_FFFF_FFE3);

    // CBZ positive (also shifted variant) and negative
    push_one({8'b1011_0100, 19'b001_1110_0011_1111_1010, 5'd0});
    chk("cbz_pos_imm",    out_imm,        64'h0000_0000_0001_E3FA);
    chk("cbz_pos_fmt",    64'(out_fmt),   64'd2);
    chk("cbz_shift_imm",  out_imm2,       64'h0000_0000_0007_8FE8);
    push_one({8'b1011_0100, 19'b101_1110_0011_1111_1010, 5'd0});
    chk("cbz_neg_imm",    out_imm,        64'hFFFF_FFFF_FFFD_E3FA);

    // B with all-ones offset (-1), shifted gives -4
    push_one({6'b000101, 26'h3FF_FFFF});
    chk("b_imm",          out_imm,        64'hFFFF_FFFF_FFFF_FFFF);
    chk("b_fmt",          64'(out_fmt),   64'd3);
    chk("b_shift_imm",    out_imm2,       64'hFFFF_FFFF_FFFF_FFFC);

    // ADDI zero-extends its 12-bit field
    push_one({10'b10_0100_0100, 12'hFFF, 10'd0});
    chk("addi_imm",       out_imm,        64'h0000_0000_0000_0FFF);
    chk("addi_fmt",       64'(out_fmt),   64'd4);

    // ADD: recognised R format
    push_one({11'b100_0101_1000, 21'h1F_FFFF});
    chk("add_imm",        out_imm,        64'd0);
    chk("add_fmt",        64'(out_fmt),   64'd0);
    chk("add_bad",        64'(out_bad),   64'd0);

    // All-zero word is unrecognised
    push_one(32'h0000_0000);
    chk("zero_imm",       out_imm,        64'd0);
    chk("zero_bad",       64'(out_bad),   64'd1);
    chk("zero_bad_cnt",   64'(bad_cnt),   64'd1);

    // 300 more bad words saturate the counter
    instr    = 32'h0000_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    chk("bad_cnt_sat",    64'(bad_cnt),   64'd255);
    chk("drained_valid",  64'(out_valid), 64'd0);

    // Backpressure: third word must not be accepted
    out_ready = 1'b0;
    instr     = ldur(9'h011);
    in_valid  = 1'b1;
    tick();
    chk("bp_ready_1",     64'(in_ready),  64'd1);
    instr = ldur(9'h022);
    tick();
    chk("bp_ready_full",  64'(in_ready),  64'd0);
    chk("bp_head_a",      out_imm,        64'h11);
    instr = ldur(9'h033);
    tick();
    chk("bp_ready_still", 64'(in_ready),  64'd0);
    chk("bp_head_hold",   out_imm,        64'h11);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_head_b",      out_imm,        64'h22);
    chk("bp_ready_back",  64'(in_ready),  64'd1);
    tick();
    chk("bp_empty",       64'(out_valid), 64'd0);
    chk("bp_empty_imm",   out_imm,        64'd0);

    // Streaming: one result per cycle across pointer wrap
    for (int i = 0; i < 10; i++) begin
      instr    = ldur(9'(i + 1));
      in_valid = 1'b1;
      tick();
      chk($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("stream_imm_%0d", i),   out_imm,        64'(i + 1));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset with two entries queued
    out_ready = 1'b0;
    push_one(ldur(9'h044));
    push_one(ldur(9'h055));
    chk("pre_rst_valid",  64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid",   64'(out_valid), 64'd0);
    chk("async_rst_imm",     out_imm,        64'd0);
    chk("async_rst_bad_cnt", 64'(bad_cnt),   64'd0);
    chk("async_rst_ready",   64'(in_ready),  64'd0);
    tick();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("rel_in_ready",   64'(in_ready),  64'd1);
    chk("rel_valid_0",    64'(out_valid), 64'd0);
    tick();
    chk("rel_valid_1",    64'(out_valid), 64'd0);
    tick();
    chk("rel_valid_2",    64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signext_pipe.md
Name: signext_pipe

Overview:
- Parametrised, buffered successor to the combinational LEGv8 sign-extension unit.
- Decodes the instruction format from opcode bits, extracts the immediate, and sign- or zero-extends it to N bits.
- Optionally pre-shifts branch offsets by 2.
- Results are queued in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Sits between the instruction-fetch/decode register and the ALU-source/branch-target logic.
- Also counts unrecognised encodings.

Parameters:
- N, 64: output immediate width; legal range 32..64.
- DEPTH, 2: result FIFO entries; power of 2, >=2.
- SHIFT_BR, 0: 1 = CB and B immediates are shifted left by 2 after extension.
- CNT_W, 8: width of the saturating unknown-encoding counter.

Ports:
- clk  in  1  clock; rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  instr holds a word to extend.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  instruction word.
- out_valid  out  1  out_imm/out_fmt/out_bad are valid.
- out_ready  in  1  consumer accepts this cycle.
- out_imm  out  N  extended immediate.
- out_fmt  out  3  format: 0 R/none, 1 D, 2 CB, 3 B, 4 I.
- out_bad  out  1  encoding not recognised.
- bad_cnt  out  CNT_W  saturating count of accepted unrecognised words.

Behaviour:
- Decode, combinational on instr, first match wins:
  - D: instr[31:21] = 111_1100_0010 (LDUR) or 111_1100_0000 (STUR). imm = sext(instr[20:12]), fmt 1.
  - CB: instr[31:24] = 1011_0100 (CBZ). imm = sext(instr[23:5]), fmt 2.
  - B: instr[31:26] = 000101. imm = sext(instr[25:0]), fmt 3.
  - I: instr[31:22] = 10_0100_0100 (ADDI) or 11_0100_0100 (SUBI). imm = zext(instr[21:10]), fmt 4.
  - R: instr[31:21] in {100_0101_1000 ADD, 110_0101_1000 SUB, 100_0101_0000 AND, 101_0101_0000 ORR}. imm = 0, fmt 0.
  - Anything else: imm = 0, fmt 0, bad = 1.
- SHIFT_BR=1: CB/B imm = sext(field) << 2, truncated to N bits. Other formats are unaffected.
- Push: in_valid & in_ready writes {imm, fmt, bad} at wr_ptr; wr_ptr++ mod DEPTH.
- Pop: out_valid & out_ready; rd_ptr++ mod DEPTH.
- count tracks occupancy 0..DEPTH. Simultaneous push and pop leaves count unchanged.
- in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0).
- out_imm/out_fmt/out_bad read the rd_ptr entry. They are forced to 0 while out_valid = 0.
- Latency: a word accepted at edge k is visible with out_valid = 1 after edge k. There is no combinational bypass.
- Ordering is strictly FIFO. Outputs are held stable while out_valid & !out_ready.
- bad_cnt increments on each accepted push with bad = 1. It saturates at 2^CNT_W - 1 and never wraps.
- Pointer wrap-around at DEPTH is seamless with no bubble. Sustained in_valid/out_ready = 1 gives one result per cycle.
- Reset (reset = 0, any time including mid-stream) immediately:
  - clears count, pointers and bad_cnt;
  - drives out_valid = 0, out_imm/out_fmt/out_bad = 0, in_ready = 0.
- Queued entries are discarded by reset. in_ready rises to 1 on the first clock edge after reset deasserts.

Test Plan:
- N=64, out_ready=1. Push LDUR with imm9 0_1110_0011, then imm9 1_1110_0011 -> out_imm 64'h0000_0000_0000_00E3 (fmt 1), then 64'hFFFF_FFFF_FFFF_FFE3, one cycle after each push.
- Push CBZ with imm19 001_1110_0011_1111_1010, then 101_1110_0011_1111_1010 -> 64'h0000_0000_0001_E3FA, then 64'hFFFF_FFFF_FFFD_E3FA, fmt 2.
  - Repeat with SHIFT_BR=1 on the positive case -> 64'h0000_0000_0007_8FE8.
- Push ADD (opcode 100_0101_1000) -> out_imm 0, fmt 0, bad 0.
  - Push 32'h0000_0000 -> out_imm 0, bad 1, bad_cnt 1.
  - Push 300 zero words with CNT_W=8 -> bad_cnt holds 255.
- out_ready=0, push 3 LDURs with DEPTH=2 -> in_ready=0 after the 2nd accept; the 3rd is not accepted.
  - Raise out_ready -> the first two emerge in order; in_ready returns 1 the cycle after the first pop.
- Continuous push/pop for 10 words with DEPTH=2 -> 10 results in order, one per cycle, with pointer wrap and no bubbles.
- Assert reset with 2 entries queued -> out_valid=0, bad_cnt=0, outputs 0 immediately. After release, in_ready=1 and no stale entry ever appears.
